// File: rtl/i2s_tx_if.sv
// Sample-side and I2S-side signals of the i2s_tx serializer.
// The slave modport is the serializer's view; the master modport is the view of its environment.
interface i2s_tx_if;
  logic        clk_en_i;
  logic [32:0] result_i;
  logic        done_i;
  logic        bclk_o;
  logic        lrclk_o;
  logic        sdata_o;
  logic        underrun_o;
  logic        overrun_o;

  modport master (
    output clk_en_i, result_i, done_i,
    input  bclk_o, lrclk_o, sdata_o, underrun_o, overrun_o
  );

  modport slave (
    input  clk_en_i, result_i, done_i,
    output bclk_o, lrclk_o, sdata_o, underrun_o, overrun_o
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: scales 33-bit dsp results to 24-bit samples and sends them mono-on-stereo.
// Define I2S_TX_SAT_EN to clamp out-of-range samples instead of wrapping them.
module i2s_tx #(
  parameter int BCLK_DIV   = 4,
  parameter int GAIN_SHIFT = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  i2s_tx_if.slave  bus
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;
  logic [5:0]       bit_cnt_reg;
  logic [5:0]       bit_cnt_next;
  logic             bclk_reg;
  logic             lrclk_reg;
  logic             sdata_reg;
  logic             underrun_reg;
  logic             overrun_reg;
  logic [23:0]      frame_reg;
  logic [23:0]      hold_reg;
  logic             hold_full_reg;
  logic [23:0]      sample_next;
  logic [63:0]      frame_bits;
  logic             div_wrap;
  logic             fall_evt;
  logic             frame_load;

`ifdef I2S_TX_SAT_EN
  localparam logic signed [32:0] SAT_MAX = 33'sh0_007F_FFFF;
  localparam logic signed [32:0] SAT_MIN = -33'sh0_0080_0000;

  logic signed [32:0] scaled;

  assign scaled = $signed(bus.result_i) >>> GAIN_SHIFT;

  always_comb begin
    sample_next = scaled[23:0];
    if (scaled > SAT_MAX) begin
      sample_next = 24'h7F_FFFF;
    end else if (scaled < SAT_MIN) begin
      sample_next = 24'h80_0000;
    end
  end
`else
  assign sample_next = 24'($signed(bus.result_i) >>> GAIN_SHIFT);
`endif

  // Static 64-slot frame map: one pad bit after each word-select edge, then 24 data bits.
  for (genvar gi = 0; gi < 64; gi++) begin : g_map
    if ((gi % 32) >= 1 && (gi % 32) <= 24) begin : g_data
      assign frame_bits[gi] = frame_reg[24 - (gi % 32)];
    end else begin : g_pad
      assign frame_bits[gi] = 1'b0;
    end
  end

  assign div_wrap     = bus.clk_en_i && (div_cnt_reg == DIV_LAST);
  assign fall_evt     = div_wrap && bclk_reg;
  assign div_cnt_next = div_wrap ? '0 : div_cnt_reg + DIV_W'(1);
  assign bit_cnt_next = bit_cnt_reg + 6'd1;
  assign frame_load   = fall_evt && (bit_cnt_next == 6'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= 6'h3F;
      bclk_reg      <= 1'b0;
      lrclk_reg     <= 1'b0;
      sdata_reg     <= 1'b0;
      underrun_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else begin
      underrun_reg <= frame_load && !hold_full_reg;
      // A load on the same cycle empties the slot, so the new sample is not an overrun.
      overrun_reg  <= bus.done_i && hold_full_reg && !frame_load;

      if (frame_load && hold_full_reg) begin
        frame_reg <= hold_reg;
      end

      if (bus.done_i) begin
        hold_reg      <= sample_next;
        hold_full_reg <= 1'b1;
      end else if (frame_load) begin
        hold_full_reg <= 1'b0;
      end

      if (bus.clk_en_i) begin
        div_cnt_reg <= div_cnt_next;
        if (div_wrap) begin
          bclk_reg <= ~bclk_reg;
        end
        if (fall_evt) begin
          bit_cnt_reg <= bit_cnt_next;
          lrclk_reg   <= bit_cnt_next[5];
          sdata_reg   <= frame_bits[bit_cnt_next];
        end
      end
    end
  end

  assign bus.bclk_o     = bclk_reg;
  assign bus.lrclk_o    = lrclk_reg;
  assign bus.sdata_o    = sdata_reg;
  assign bus.underrun_o = underrun_reg;
  assign bus.overrun_o  = overrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a DAC-side monitor decodes frames on bclk rises and
// compares them against a queue of expected samples filled as stimulus is driven.
module tb_i2s_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  i2s_tx_if bus();

  i2s_tx #(.BCLK_DIV(4), .GAIN_SHIFT(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int cyc    = 0;

  logic [23:0] exp_q[$];

  int   fall_idx    = 63;
  bit   valid       = 1'b0;
  logic bclk_prev   = 1'b0;
  logic und_prev    = 1'b0;
  logic ovr_prev    = 1'b0;
  int   fs_cnt      = 0;
  int   fs_cyc      = 0;
  int   und_cnt     = 0;
  int   und_cyc     = -1;
  int   ovr_cnt     = 0;
  int   frames_done = 0;
  logic [23:0] left_w  = '0;
  logic [23:0] right_w = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [32:0] r);
    @(posedge clk); #1;
    bus.result_i = r;
    bus.done_i   = 1'b1;
    @(posedge clk); #1;
    bus.done_i   = 1'b0;
  endtask

  task automatic wait_fs();
    int start;
    int n;
    start = fs_cnt;
    n = 0;
    while (fs_cnt == start && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("frame_start_seen", 32'(fs_cnt != start), 1);
  endtask

  task automatic wait_fall(input int idx);
    int n;
    n = 0;
    while (!(valid && fall_idx == idx) && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check("bit_reached", 32'(valid && fall_idx == idx), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // DAC-side monitor: bit position follows bclk falls, data is taken on bclk rises.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        fall_idx  = 63;
        valid     = 1'b0;
        bclk_prev = 1'b0;
        und_prev  = 1'b0;
        ovr_prev  = 1'b0;
      end else begin
        if (bclk_prev && !bus.bclk_o) begin
          fall_idx = (fall_idx + 1) % 64;
          if (fall_idx == 0) begin
            fs_cnt++;
            fs_cyc = cyc;
          end
        end
        if (!bclk_prev && bus.bclk_o) begin
          if (fall_idx == 0) begin
            valid   = 1'b1;
            left_w  = '0;
            right_w = '0;
          end
          if (valid) begin
            check("lrclk_level", bus.lrclk_o, fall_idx / 32);
            if (fall_idx >= 1 && fall_idx <= 24) begin
              left_w[24 - fall_idx] = bus.sdata_o;
            end else if (fall_idx >= 33 && fall_idx <= 56) begin
              right_w[56 - fall_idx] = bus.sdata_o;
            end else begin
              check("pad_bit", bus.sdata_o, 0);
            end
            if (fall_idx == 63) begin
              frames_done++;
              check("frame_queue_nonempty", 32'(exp_q.size() != 0), 1);
              if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("left_word", left_w, e);
                check("right_word", right_w, e);
                $display("frame %0d: left=%06h right=%06h expected=%06h", frames_done, left_w, right_w, e);
              end
            end
          end
        end
        if (bus.underrun_o) begin
          und_cnt++;
          und_cyc = cyc;
          check("underrun_width", und_prev, 0);
        end
        if (bus.overrun_o) begin
          ovr_cnt++;
          check("overrun_width", ovr_prev, 0);
        end
        bclk_prev = bus.bclk_o;
        und_prev  = bus.underrun_o;
        ovr_prev  = bus.overrun_o;
      end
    end
  end

  initial begin
    int rel;
    int fs5;
    logic [2:0] snap;

    bus.clk_en_i = 1'b1;
    bus.done_i   = 1'b0;
    bus.result_i = '0;

    // Reset: outputs zero while held, bclk rises at 4, first frame start at 8.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("reset_outputs", {bus.bclk_o, bus.lrclk_o, bus.sdata_o, bus.underrun_o, bus.overrun_o}, 0);
    end
    rst = 1'b0;
    rel = cyc;
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) begin
        bus.result_i = 33'h0_1234_5600;
        bus.done_i   = 1'b1;
        exp_q.push_back(24'h123456);
      end else begin
        bus.done_i = 1'b0;
      end
      @(posedge clk); #1;
      check("startup_bclk", bus.bclk_o, (k >= 4 && k < 8) ? 1 : 0);
      check("startup_others", {bus.lrclk_o, bus.sdata_o, bus.underrun_o, bus.overrun_o}, 0);
    end
    @(negedge clk); #1;
    check("first_frame_cycle", fs_cyc - rel, 8);
    check("first_frame_count", fs_cnt, 1);

    // Conversion of a positive overflow value.
    repeat (100) @(negedge clk);
    send(33'h0_FFFF_FF00);
`ifdef I2S_TX_SAT_EN
    exp_q.push_back(24'h7FFFFF);
`else
    exp_q.push_back(24'hFFFFFF);
`endif
    wait_fs();

    // Conversion of a negative overflow value.
    repeat (100) @(negedge clk);
    send(33'h1_0000_0000);
`ifdef I2S_TX_SAT_EN
    exp_q.push_back(24'h800000);
`else
    exp_q.push_back(24'h000000);
`endif
    wait_fs();

    // Underrun: one sample, then silence; it repeats with a single underrun pulse.
    repeat (100) @(negedge clk);
    send(33'h0_0001_1100);
    exp_q.push_back(24'h000111);
    exp_q.push_back(24'h000111);
    wait_fs();
    check("no_underrun_yet", und_cnt, 0);
    wait_fs();
    check("underrun_count", und_cnt, 1);
    check("underrun_at_frame_start", und_cyc, fs_cyc);

    // Overrun: second sample in the same frame replaces the first.
    repeat (50) @(negedge clk);
    send(33'h0_0004_0000);
    @(negedge clk); #1;
    check("no_overrun_first", ovr_cnt, 0);
    repeat (50) @(negedge clk);
    send(33'h0_0002_0000);
    @(negedge clk); #1;
    check("overrun_count", ovr_cnt, 1);
    exp_q.push_back(24'h000200);
    wait_fs();
    check("no_underrun_frame5", und_cnt, 1);
    fs5 = fs_cyc;

    // Collision: a done on the frame-load edge goes to the following frame.
    repeat (100) @(negedge clk);
    send(33'h0_0002_2200);
    exp_q.push_back(24'h000222);
    while (cyc < fs5 + 510) @(negedge clk);
    send(33'h0_0003_3300);
    exp_q.push_back(24'h000333);
    @(negedge clk); #1;
    check("collision_load_cycle", fs_cyc, fs5 + 512);
    check("collision_no_overrun", ovr_cnt, 1);
    check("collision_no_underrun", und_cnt, 1);

    // Freeze at bit 10 of the next frame; capture still works while frozen.
    wait_fs();
    wait_fall(10);
    @(posedge clk); #1;
    bus.clk_en_i = 1'b0;
    snap = {bus.bclk_o, bus.lrclk_o, bus.sdata_o};
    for (int i = 0; i < 20; i++) begin
      bus.done_i = (i == 5);
      if (i == 5) bus.result_i = 33'h0_0004_4400;
      @(posedge clk); #1;
      check("freeze_outputs", {bus.bclk_o, bus.lrclk_o, bus.sdata_o}, snap);
    end
    bus.done_i   = 1'b0;
    bus.clk_en_i = 1'b1;
    exp_q.push_back(24'h000444);
    wait_fs();
    check("frozen_capture_loaded", und_cnt, 1);

    // Reset at bit 40: frame abandoned, restart from bit 0 with an empty holding register.
    wait_fall(40);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_outputs", {bus.bclk_o, bus.lrclk_o, bus.sdata_o, bus.underrun_o, bus.overrun_o}, 0);
    void'(exp_q.pop_front());
    rst = 1'b0;
    rel = cyc;
    exp_q.push_back(24'h000000);
    wait_fs();
    check("midreset_frame_cycle", fs_cyc - rel, 8);
    check("midreset_underrun", und_cnt, 2);
    check("midreset_underrun_cycle", und_cyc, fs_cyc);

    for (int n = 0; n < 1200 && frames_done < 9; n++) @(negedge clk);
    check("frames_done", frames_done, 9);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
